muldiv_ctrl: RTL and testbench

- Sequencer between the multicycle CPU control unit and the shared iterative multiplier/divider datapath.
- Accepts a one-cycle start request for MULT or DIV and drives the unit's operation-enable for the exact iteration count.
- Captures the 64-bit result into architectural HI/LO registers and signals completion; DIV with a zero divisor raises an exception instead.
- Control unit stalls on busy; MFHI/MFLO read hi/lo directly.

---
 rtl/muldiv_ctrl.sv | 113 +++++++++++
 tb/tb_muldiv_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// MULT/DIV sequencer: drives the iterative unit's enable for a fixed
// iteration count, then captures the 64-bit result into HI/LO.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 33,
  parameter int DIV_CYCLES  = 33,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] divisor,
  input  logic [31:0] mult_hi_in,
  input  logic [31:0] mult_lo_in,
  input  logic [31:0] div_hi_in,
  input  logic [31:0] div_lo_in,
  output logic        multOp,
  output logic        divOp,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    CAPTURE,
    DZERO
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_div;

  // Enable stays high through CAPTURE so the unit's result is not cleared
  // before it is sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      multOp   <= 1'b0;
      divOp    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_mult) begin
            state  <= MULT_RUN;
            multOp <= 1'b1;
            busy   <= 1'b1;
            cnt    <= '0;
            op_div <= 1'b0;
          end else if (start_div) begin
            if (divisor != 32'd0) begin
              state  <= DIV_RUN;
              divOp  <= 1'b1;
              busy   <= 1'b1;
              cnt    <= '0;
              op_div <= 1'b1;
            end else begin
              state <= DZERO;
              busy  <= 1'b1;
            end
          end
        end
        MULT_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == MULT_LAST)
            state <= CAPTURE;
        end
        DIV_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == DIV_LAST)
            state <= CAPTURE;
        end
        CAPTURE: begin
          hi     <= op_div ? div_hi_in : mult_hi_in;
          lo     <= op_div ? div_lo_in : mult_lo_in;
          multOp <= 1'b0;
          divOp  <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        DZERO: begin
          div_zero <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state  <= IDLE;
          multOp <= 1'b0;
          divOp  <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural iterative unit plus a result scoreboard.
module tb_muldiv_ctrl;

  localparam int N = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult, start_div;
  logic [31:0] divisor;
  logic [31:0] mult_hi_in, mult_lo_in, div_hi_in, div_lo_in;
  logic        multOp, divOp, busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] sb[$];
  logic [63:0] exp_v;

  // shared-unit model operands
  logic [31:0] m_a = 0, m_b = 0, d_a = 0, d_b = 1;
  int          mcnt = 0, dcnt = 0;
  logic signed [63:0] m_res;
  logic [63:0] d_res;

  muldiv_ctrl #(.MULT_CYCLES(N), .DIV_CYCLES(N), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .start_mult(start_mult), .start_div(start_div),
    .divisor(divisor),
    .mult_hi_in(mult_hi_in), .mult_lo_in(mult_lo_in),
    .div_hi_in(div_hi_in), .div_lo_in(div_lo_in),
    .multOp(multOp), .divOp(divOp), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Unit produces final values only after N enabled clocks; cleared when off.
  always @(posedge clk) begin
    if (!multOp) mcnt <= 0;
    else if (mcnt < N) mcnt <= mcnt + 1;
    if (!divOp) dcnt <= 0;
    else if (dcnt < N) dcnt <= dcnt + 1;
  end

  always_comb begin
    m_res = $signed(m_a) * $signed(m_b);
    d_res = (d_b != 0) ? {d_a % d_b, d_a / d_b} : 64'd0;
    mult_hi_in = (mcnt >= N) ? m_res[63:32] : (32'hBAD00000 | 32'(mcnt));
    mult_lo_in = (mcnt >= N) ? m_res[31:0]  : (32'hBAD10000 | 32'(mcnt));
    div_hi_in  = (dcnt >= N) ? d_res[63:32] : (32'hBAD20000 | 32'(dcnt));
    div_lo_in  = (dcnt >= N) ? d_res[31:0]  : (32'hBAD30000 | 32'(dcnt));
  end

  task automatic pulse(input logic m, input logic d, input logic [31:0] dv);
    start_mult = m;
    start_div  = d;
    divisor    = dv;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  task automatic wait_done(output int k, output int em, output int ed);
    k = 0; em = 0; ed = 0;
    while (!done && k < 100) begin
      if (multOp) em++;
      if (divOp) ed++;
      @(negedge clk);
      k++;
    end
    if (!done) k = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start_mult = 0; start_div = 0; divisor = 0;
    @(negedge clk);
    n_cmp++;
    if ({multOp, divOp, busy, done, div_zero, hi, lo} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %b/%h/%h want 0", {multOp, divOp, busy, done, div_zero}, hi, lo);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int k, em, ed;
    m_a = 32'd7; m_b = -32'sd3;
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    pulse(1, 0, 0);
    n_cmp++;
    if (!(multOp && busy)) begin
      n_bad++; $display("FAIL mult_start: multOp=%b busy=%b want 1/1", multOp, busy);
    end
    wait_done(k, em, ed);
    n_cmp++;
    if (k !== N + 1) begin n_bad++; $display("FAIL mult_latency: got %0d want %0d", k, N + 1); end
    n_cmp++;
    if (em !== N + 1 || ed !== 0) begin
      n_bad++; $display("FAIL mult_enable: multOp %0d divOp %0d want %0d/0", em, ed, N + 1);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mult_busy: got %b want 0", busy); end
    exp_v = (sb.size() != 0) ? sb.pop_front() : 64'hX;
    n_cmp++;
    if ({hi, lo} !== exp_v) begin n_bad++; $display("FAIL mult_result: got %h want %h", {hi, lo}, exp_v); end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %b want 0", done); end
  endtask

  task automatic test_div;
    int k, em, ed;
    d_a = 32'd100; d_b = 32'd7;
    sb.push_back({32'd2, 32'd14});
    pulse(0, 1, 32'd7);
    wait_done(k, em, ed);
    n_cmp++;
    if (k !== N + 1) begin n_bad++; $display("FAIL div_latency: got %0d want %0d", k, N + 1); end
    n_cmp++;
    if (ed !== N + 1 || em !== 0) begin
      n_bad++; $display("FAIL div_enable: divOp %0d multOp %0d want %0d/0", ed, em, N + 1);
    end
    exp_v = (sb.size() != 0) ? sb.pop_front() : 64'hX;
    n_cmp++;
    if ({hi, lo} !== exp_v) begin n_bad++; $display("FAIL div_result: got %h want %h", {hi, lo}, exp_v); end
  endtask

  task automatic test_div_zero;
    int k, em, ed, dz, dn, dop;
    d_a = 32'd95; d_b = 32'd10;
    sb.push_back({32'd5, 32'd9});
    pulse(0, 1, 32'd10);
    wait_done(k, em, ed);
    exp_v = (sb.size() != 0) ? sb.pop_front() : 64'hX;
    n_cmp++;
    if ({hi, lo} !== exp_v) begin n_bad++; $display("FAIL preload: got %h want %h", {hi, lo}, exp_v); end
    @(negedge clk);
    d_b = 0;
    pulse(0, 1, 32'd0);
    n_cmp++;
    if (busy !== 1'b1 || div_zero !== 1'b0) begin
      n_bad++; $display("FAIL dz_k0: busy=%b div_zero=%b want 1/0", busy, div_zero);
    end
    @(negedge clk);
    n_cmp++;
    if (div_zero !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL dz_pulse: div_zero=%b busy=%b want 1/0", div_zero, busy);
    end
    dz = 0; dn = 0; dop = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dz += int'(div_zero); dn += int'(done); dop += int'(divOp);
    end
    n_cmp++;
    if (dz !== 0 || dn !== 0 || dop !== 0) begin
      n_bad++; $display("FAIL dz_after: div_zero %0d done %0d divOp %0d want 0/0/0", dz, dn, dop);
    end
    n_cmp++;
    if (hi !== 32'd5 || lo !== 32'd9) begin
      n_bad++; $display("FAIL dz_hilo: got %h/%h want 5/9", hi, lo);
    end
  endtask

  task automatic test_both_starts;
    int dones, dop;
    m_a = 32'd3; m_b = 32'd4;
    d_a = 32'd50; d_b = 32'd5;
    sb.push_back({32'd0, 32'd12});
    pulse(1, 1, 32'd5);
    dones = 0; dop = 0;
    for (int k = 0; k < 60; k++) begin
      if (divOp) dop++;
      if (done) begin
        dones++;
        exp_v = (sb.size() != 0) ? sb.pop_front() : 64'hX;
        n_cmp++;
        if ({hi, lo} !== exp_v) begin n_bad++; $display("FAIL both_result: got %h want %h", {hi, lo}, exp_v); end
      end
      start_div = (k == 5);
      divisor   = 32'd5;
      @(negedge clk);
    end
    start_div = 1'b0;
    n_cmp++;
    if (dones !== 1 || dop !== 0) begin
      n_bad++; $display("FAIL both_starts: dones %0d divOp %0d want 1/0", dones, dop);
    end
  endtask

  task automatic test_back_to_back;
    int k, em, ed;
    m_a = 32'd6; m_b = 32'd7;
    sb.push_back({32'd0, 32'd42});
    pulse(1, 0, 0);
    wait_done(k, em, ed);
    exp_v = (sb.size() != 0) ? sb.pop_front() : 64'hX;
    n_cmp++;
    if ({hi, lo} !== exp_v) begin n_bad++; $display("FAIL b2b_mult: got %h want %h", {hi, lo}, exp_v); end
    d_a = 32'd1000; d_b = 32'd3;
    sb.push_back({32'd1, 32'd333});
    pulse(0, 1, 32'd3);
    n_cmp++;
    if (divOp !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_rise: divOp=%b busy=%b want 1/1", divOp, busy);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({hi, lo} !== {32'd0, 32'd42}) begin
      n_bad++; $display("FAIL b2b_hold: got %h want %h", {hi, lo}, {32'd0, 32'd42});
    end
    wait_done(k, em, ed);
    n_cmp++;
    if (k + 20 !== N + 1) begin n_bad++; $display("FAIL b2b_latency: got %0d want %0d", k + 20, N + 1); end
    exp_v = (sb.size() != 0) ? sb.pop_front() : 64'hX;
    n_cmp++;
    if ({hi, lo} !== exp_v) begin n_bad++; $display("FAIL b2b_div: got %h want %h", {hi, lo}, exp_v); end
  endtask

  task automatic test_reset_mid;
    int dones;
    m_a = 32'd9; m_b = 32'd9;
    pulse(1, 0, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (multOp !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++; $display("FAIL reset_mid: multOp=%b busy=%b hi=%h lo=%h want 0", multOp, busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      dones += int'(done) + int'(multOp);
    end
    n_cmp++;
    if (dones !== 0) begin n_bad++; $display("FAIL reset_abandon: activity %0d want 0", dones); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_both_starts;
    test_back_to_back;
    test_reset_mid;
    n_cmp++;
    if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
